// File: rtl/position_move_ctrl_pkg.sv
// Shared definitions for the position move controller.
//   state_e   : FSM state encoding (IDLE, MOVE, SETTLE, DONE)
//   status_e  : completion status codes reported on the status port
//   cnt_width : bit width needed for a counter that must hold a given terminal value
package position_move_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StMove   = 2'b01,
      StSettle = 2'b10,
      StDone   = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      StatusOk      = 2'b00,
      StatusAborted = 2'b01,
      StatusTimeout = 2'b10
   } status_e;

   function automatic int unsigned cnt_width(input int unsigned terminal);
      return (terminal < 2) ? 1 : $clog2(terminal + 1);
   endfunction

endpackage

// File: rtl/move_timer.sv
// Cycle counter with synchronous clear, count enable and a terminal-compare output.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset, clears the count
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count this cycle
//   hit_o  : the count reaches Terminal on the coming edge (en_i high, count at Terminal-1)
module move_timer
   import position_move_ctrl_pkg::*;
#(
   parameter int unsigned Width    = 8,
   parameter int unsigned Terminal = 100
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);

   localparam logic [Width-1:0] Last = Width'(Terminal - 1);
   localparam logic [Width-1:0] Term = Width'(Terminal);

   logic [Width-1:0] cnt_q, cnt_d;

   // Saturates at Terminal so a held enable can never wrap back into range.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != Term)) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags the edge on which the count becomes Terminal, so the owner can act on that same edge.
   assign hit_o = en_i && (cnt_q == Last);

endmodule

// File: rtl/position_move_ctrl.sv
// Closed-loop point-to-point move controller for a quadrature-encoded axis.
//   CLOCK_50   : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   cmd_valid  : move command present;  cmd_ready : command can be accepted (IDLE only)
//   cmd_target : target position, two's complement
//   abort      : terminate the current move
//   enc_count  : encoder position, two's complement, synchronous to CLOCK_50
//   motor_en   : drive enable;  motor_dir : 1 drives toward increasing count
//   busy       : move in progress;  done : one-cycle completion pulse
//   status     : 00 ok, 01 aborted, 10 timeout; held until the next accept
module position_move_ctrl
   import position_move_ctrl_pkg::*;
#(
   parameter int unsigned COUNTBITS      = 24,
   parameter int unsigned TOL            = 4,
   parameter int unsigned SETTLE_CYCLES  = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic                 CLOCK_50,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [COUNTBITS-1:0] cmd_target,
   input  logic                 abort,
   input  logic [COUNTBITS-1:0] enc_count,
   output logic                 motor_en,
   output logic                 motor_dir,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           status
);

   localparam int unsigned SettleW  = cnt_width(SETTLE_CYCLES);
   localparam int unsigned TimeoutW = cnt_width(TIMEOUT_CYCLES);
   localparam logic signed [COUNTBITS:0] TolS = (COUNTBITS + 1)'(TOL);

   state_e               state_q;
   status_e              status_q;
   logic [COUNTBITS-1:0] target_q;
   logic                 motor_en_q, motor_dir_q, busy_q, done_q, cmd_ready_q;

   logic [COUNTBITS-1:0]      err_tgt;
   logic signed [COUNTBITS:0] err;
   logic                      in_window, err_pos, accept, active;
   logic                      settle_en, settle_hit, timeout_hit;

   assign accept = cmd_valid && cmd_ready_q;
   assign active = (state_q == StMove) || (state_q == StSettle);

   // On the accept cycle the target is not registered yet, so the first direction is taken
   // from the command itself.
   assign err_tgt = (state_q == StIdle) ? cmd_target : target_q;

   // One extra bit keeps the difference of two full-range positions from wrapping.
   assign err = $signed({err_tgt[COUNTBITS-1], err_tgt})
              - $signed({enc_count[COUNTBITS-1], enc_count});

   assign in_window = (err <= TolS) && (err >= -TolS);
   assign err_pos   = !err[COUNTBITS] && (err != '0);

   // Any out-of-window cycle in SETTLE (or leaving SETTLE) restarts the settle count.
   assign settle_en = (state_q == StSettle) && in_window;

   move_timer #(
      .Width    (SettleW),
      .Terminal (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk_i  (CLOCK_50),
      .rst_ni (rst_n),
      .clr_i  (!settle_en),
      .en_i   (settle_en),
      .hit_o  (settle_hit)
   );

   move_timer #(
      .Width    (TimeoutW),
      .Terminal (TIMEOUT_CYCLES)
   ) u_timeout_timer (
      .clk_i  (CLOCK_50),
      .rst_ni (rst_n),
      .clr_i  (accept),
      .en_i   (active),
      .hit_o  (timeout_hit)
   );

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         status_q    <= StatusOk;
         target_q    <= '0;
         motor_en_q  <= 1'b0;
         motor_dir_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               cmd_ready_q <= 1'b1;
               if (accept) begin
                  state_q     <= StMove;
                  status_q    <= StatusOk;
                  target_q    <= cmd_target;
                  motor_en_q  <= 1'b1;
                  motor_dir_q <= err_pos;
                  busy_q      <= 1'b1;
                  cmd_ready_q <= 1'b0;
               end
            end
            StMove, StSettle: begin
               // Priority: abort, then timeout, then settle complete.
               if (abort || timeout_hit || settle_hit) begin
                  state_q    <= StDone;
                  motor_en_q <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  if (abort) begin
                     status_q <= StatusAborted;
                  end else if (timeout_hit) begin
                     status_q <= StatusTimeout;
                  end else begin
                     status_q <= StatusOk;
                  end
               end else if (in_window) begin
                  state_q    <= StSettle;
                  motor_en_q <= 1'b0;
               end else begin
                  state_q     <= StMove;
                  motor_en_q  <= 1'b1;
                  motor_dir_q <= err_pos;
               end
            end
            StDone: begin
               state_q     <= StIdle;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign motor_en  = motor_en_q;
   assign motor_dir = motor_dir_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign status    = status_q;

endmodule

// File: tb/tb_position_move_ctrl.sv
// Bench for position_move_ctrl: two instances (default timeout, and a 200-cycle timeout),
// an encoder model that steps one count per enabled cycle in the commanded direction,
// a vector table with a scoreboard queue, and hand-written overshoot, idle-abort and
// mid-move reset sequences.
module tb_position_move_ctrl;

   localparam int unsigned CB        = 24;
   localparam int unsigned ToShort   = 200;
   localparam int          MaxCycles = 3000;
   localparam int          NumVecs   = 10;

   typedef struct {
      int         inst;
      int         start;
      int         target;
      bit         frz;
      int         abort_at;        // post-accept cycle in which abort is held high, 0 = never
      bit         exp_dir;
      logic [1:0] exp_status;
      int         exp_done_cyc;    // post-accept cycle in which done is high
      int         exp_settle_cyc;  // first post-accept cycle in SETTLE, 0 = never
      int         exp_settle_cnt;  // encoder count on entering SETTLE
   } vec_t;

   logic               clk;
   logic [1:0]         rst_n, cmd_valid, abort, freeze;
   logic [1:0]         cmd_ready, motor_en, motor_dir, busy, done;
   logic [1:0][CB-1:0] cmd_target, enc_count;
   logic [1:0][1:0]    status;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs [NumVecs];
   vec_t sb_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   position_move_ctrl #(
      .COUNTBITS (CB)
   ) u_dut (
      .CLOCK_50   (clk),
      .rst_n      (rst_n[0]),
      .cmd_valid  (cmd_valid[0]),
      .cmd_ready  (cmd_ready[0]),
      .cmd_target (cmd_target[0]),
      .abort      (abort[0]),
      .enc_count  (enc_count[0]),
      .motor_en   (motor_en[0]),
      .motor_dir  (motor_dir[0]),
      .busy       (busy[0]),
      .done       (done[0]),
      .status     (status[0])
   );

   position_move_ctrl #(
      .COUNTBITS      (CB),
      .TIMEOUT_CYCLES (ToShort)
   ) u_to (
      .CLOCK_50   (clk),
      .rst_n      (rst_n[1]),
      .cmd_valid  (cmd_valid[1]),
      .cmd_ready  (cmd_ready[1]),
      .cmd_target (cmd_target[1]),
      .abort      (abort[1]),
      .enc_count  (enc_count[1]),
      .motor_en   (motor_en[1]),
      .motor_dir  (motor_dir[1]),
      .busy       (busy[1]),
      .done       (done[1]),
      .status     (status[1])
   );

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Encoder model: one count per cycle with the drive enabled, in the commanded direction.
   task automatic step_model();
      for (int d = 0; d < 2; d++) begin
         if (!freeze[d] && motor_en[d] === 1'b1) begin
            if (motor_dir[d]) enc_count[d] = enc_count[d] + CB'(1);
            else              enc_count[d] = enc_count[d] - CB'(1);
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   d, cyc, settle_cyc, settle_cnt;
      bit   busy_ok, first_dir, first_en;
      vec_t e;
      d = v.inst;
      freeze[d]    = v.frz;
      enc_count[d] = CB'(v.start);
      @(negedge clk);
      cmd_target[d] = CB'(v.target);
      cmd_valid[d]  = 1'b1;
      sb_q.push_back(v);
      @(negedge clk);
      cmd_valid[d] = 1'b0;
      cyc        = 1;
      busy_ok    = 1'b1;
      settle_cyc = 0;
      settle_cnt = 0;
      first_dir  = motor_dir[d];
      first_en   = motor_en[d];
      while (done[d] !== 1'b1 && cyc <= MaxCycles) begin
         if (busy[d] !== 1'b1) busy_ok = 1'b0;
         if (settle_cyc == 0 && busy[d] === 1'b1 && motor_en[d] === 1'b0) begin
            settle_cyc = cyc;
            settle_cnt = int'($signed(enc_count[d]));
         end
         abort[d] = (v.abort_at == cyc);
         step_model();
         @(negedge clk);
         cyc++;
      end
      abort[d] = 1'b0;
      e = sb_q.pop_front();
      check("done_seen", done[d], 1);
      check("move_en_cycle1", first_en, 1);
      check("move_dir", first_dir, e.exp_dir);
      check("done_cycle", cyc, e.exp_done_cyc);
      check("status", status[d], e.exp_status);
      check("busy_during_move", busy_ok, 1);
      check("busy_at_done", busy[d], 0);
      check("motor_en_at_done", motor_en[d], 0);
      check("settle_cycle", settle_cyc, e.exp_settle_cyc);
      if (e.exp_settle_cyc != 0) check("settle_count", settle_cnt, e.exp_settle_cnt);
      @(negedge clk);
      check("done_width", done[d], 0);
      check("ready_after_done", cmd_ready[d], 1);
   endtask

   initial begin
      int  n, settle_n;
      bit  seen;

      //          inst start     target    frz abort dir status done  scyc scnt
      vecs[0] = '{0, 0,        500,      0,  0,    1,  2'b00, 1497, 497, 496};
      vecs[1] = '{0, 100,      -200,     0,  0,    0,  2'b00, 1297, 297, -196};
      vecs[2] = '{1, 0,        1000,     1,  0,    1,  2'b10, 201,  0,   0};
      vecs[3] = '{0, 50,       52,       0,  0,    1,  2'b00, 1002, 2,   51};
      vecs[4] = '{0, -5,       300,      0,  50,   1,  2'b01, 51,   0,   0};
      vecs[5] = '{0, 8388600,  -8388000, 0,  3,    0,  2'b01, 4,    0,   0};
      vecs[6] = '{0, -8388600, 8388000,  0,  3,    1,  2'b01, 4,    0,   0};
      vecs[7] = '{0, 0,        4,        1,  0,    1,  2'b00, 1002, 2,   0};
      vecs[8] = '{0, 0,        -5,       1,  30,   0,  2'b01, 31,   0,   0};
      vecs[9] = '{1, 0,        1000,     1,  200,  1,  2'b01, 201,  0,   0};

      rst_n      = 2'b00;
      cmd_valid  = 2'b00;
      abort      = 2'b00;
      freeze     = 2'b00;
      cmd_target = '0;
      enc_count  = '0;

      // Reset state and release timing
      #12;
      for (int d = 0; d < 2; d++) begin
         check("rst_cmd_ready", cmd_ready[d], 0);
         check("rst_busy", busy[d], 0);
         check("rst_done", done[d], 0);
         check("rst_motor_en", motor_en[d], 0);
         check("rst_motor_dir", motor_dir[d], 0);
         check("rst_status", status[d], 0);
      end
      @(negedge clk);
      rst_n = 2'b11;
      #1;
      check("ready_before_edge", cmd_ready[0], 0);
      @(posedge clk);
      #1;
      check("ready_after_edge0", cmd_ready[0], 1);
      check("ready_after_edge1", cmd_ready[1], 1);
      @(negedge clk);

      for (int i = 0; i < NumVecs; i++) run_vec(vecs[i]);

      // Abort while idle on the timeout instance: nothing may change
      @(negedge clk);
      abort[1] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_abort_busy", busy[1], 0);
         check("idle_abort_done", done[1], 0);
         check("idle_abort_status", status[1], 1);
         check("idle_abort_ready", cmd_ready[1], 1);
      end
      abort[1] = 1'b0;

      // Overshoot during SETTLE; a command held valid while busy must be ignored
      freeze[0]    = 1'b0;
      enc_count[0] = '0;
      @(negedge clk);
      cmd_target[0] = CB'(20);
      cmd_valid[0]  = 1'b1;
      @(negedge clk);
      cmd_target[0] = CB'(-1000);
      n = 0;
      while (!(busy[0] === 1'b1 && motor_en[0] === 1'b0) && n < 100) begin
         step_model();
         @(negedge clk);
         n++;
      end
      check("ovs_settle_entry", $signed(enc_count[0]), 16);
      repeat (10) begin
         step_model();
         @(negedge clk);
      end
      cmd_valid[0] = 1'b0;
      enc_count[0] = CB'(26);
      @(negedge clk);
      check("ovs_back_to_move", motor_en[0], 1);
      check("ovs_dir", motor_dir[0], 0);
      check("ovs_busy", busy[0], 1);
      step_model();
      settle_n = 0;
      n = 0;
      @(negedge clk);
      while (done[0] !== 1'b1 && n < 1500) begin
         if (busy[0] === 1'b1 && motor_en[0] === 1'b0) settle_n++;
         step_model();
         @(negedge clk);
         n++;
      end
      check("ovs_done_seen", done[0], 1);
      check("ovs_settle_restart", settle_n, 1000);
      check("ovs_status", status[0], 0);
      @(negedge clk);
      check("ovs_ready", cmd_ready[0], 1);

      // Reset pulse in the middle of a move
      enc_count[0] = '0;
      @(negedge clk);
      cmd_target[0] = CB'(500);
      cmd_valid[0]  = 1'b1;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      repeat (20) begin
         step_model();
         @(negedge clk);
      end
      check("mid_move_en", motor_en[0], 1);
      #2;
      rst_n[0] = 1'b0;
      #1;
      check("async_rst_motor_en", motor_en[0], 0);
      check("async_rst_busy", busy[0], 0);
      check("async_rst_ready", cmd_ready[0], 0);
      check("async_rst_done", done[0], 0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      #1;
      check("rel_ready_before_edge", cmd_ready[0], 0);
      @(posedge clk);
      #1;
      check("rel_ready_after_edge", cmd_ready[0], 1);
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done[0] !== 1'b0) seen = 1'b1;
      end
      check("rst_no_done_pulse", seen, 0);
      check("rst_status_ok", status[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/position_move_ctrl.md
POSITION_MOVE_CTRL -- requirements
Module: position_move_ctrl

Interface
REQ-001 The block SHALL have parameter COUNTBITS, default 24, which sets the encoder position width.
REQ-002 The block SHALL have parameter TOL, default 4, which sets the in-position window half-width in counts.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 1000, which sets the consecutive in-window cycles required to finish.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 50000000, which sets the maximum cycles from command accept to finish.
REQ-005 The block SHALL have a port CLOCK_50, input, 1 bit: the single clock, rising-edge.
REQ-006 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have a port cmd_valid, input, 1 bit: move command present.
REQ-008 The block SHALL have a port cmd_ready, output, 1 bit: the block can accept a command.
REQ-009 The block SHALL have a port cmd_target, input, COUNTBITS bits: target position, two's complement.
REQ-010 The block SHALL have a port abort, input, 1 bit: terminate the current move.
REQ-011 The block SHALL have a port enc_count, input, COUNTBITS bits: quadrature counter position, two's complement, synchronous to CLOCK_50.
REQ-012 The block SHALL have a port motor_en, output, 1 bit: drive enable.
REQ-013 The block SHALL have a port motor_dir, output, 1 bit: 1 means drive toward an increasing count.
REQ-014 The block SHALL have a port busy, output, 1 bit: a move is in progress.
REQ-015 The block SHALL have a port done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have a port status, output, 2 bits: 00 ok, 01 aborted, 10 timeout; it holds until the next accept.

Function
REQ-017 The FSM SHALL have states IDLE, MOVE, SETTLE and DONE, and all outputs SHALL be registered or decoded from the state register only.
REQ-018 cmd_ready SHALL be 1 exactly in IDLE; a command is accepted on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-019 On accept, the block SHALL register cmd_target, clear the timeout counter and enter MOVE on the next edge.
REQ-020 The error SHALL be err = target - enc_count, computed sign-extended to COUNTBITS+1 bits, so that it never wraps.
REQ-021 The block SHALL define in-window as |err| <= TOL, computed with COUNTBITS+1-bit arithmetic.
REQ-022 In MOVE, motor_en SHALL be 1 and motor_dir SHALL be 1 when err>0 and 0 when err<0; motor_dir SHALL be registered each cycle.
REQ-023 MOVE SHALL go to SETTLE on the first in-window cycle.
REQ-024 SETTLE SHALL force motor_en=0 and count consecutive in-window cycles.
REQ-025 SETTLE SHALL return to MOVE on any out-of-window cycle and clear the settle count.
REQ-026 SETTLE SHALL go to DONE with status 00 when the settle count reaches SETTLE_CYCLES.
REQ-027 The timeout counter SHALL increment in MOVE and SETTLE; on reaching TIMEOUT_CYCLES the block SHALL go to DONE with status 10.
REQ-028 When abort=1 in MOVE or SETTLE, the block SHALL go to DONE with status 01; abort in IDLE or DONE SHALL be ignored.
REQ-029 For simultaneous events, priority SHALL be abort > timeout > settle complete.
REQ-030 DONE SHALL last exactly one cycle with done=1 and motor_en=0, then the block SHALL go to IDLE.
REQ-031 busy SHALL be 1 in MOVE and SETTLE and 0 otherwise.
REQ-032 A target already in-window at accept SHALL give MOVE for 1 cycle, then SETTLE, then DONE after SETTLE_CYCLES.
REQ-033 cmd_valid while busy SHALL have no effect.

Reset
REQ-034 While rst_n=0, the block SHALL asynchronously force state IDLE, motor_en=0, motor_dir=0, busy=0, done=0, status=00, cmd_ready=0 and clear all counters.
REQ-035 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-036 Reset mid-move SHALL stop the motor immediately without producing a done pulse.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding and the status codes (OK, ABORTED, TIMEOUT).
REQ-038 The block SHALL use one sub-module, move_timer: a counter with clear, enable and a terminal-compare output, instantiated twice (settle and timeout).

Verification
REQ-039 Bench: count=0, target=+500, with a count model that steps +1 per enabled cycle toward the target -> motor_dir=1, SETTLE entered at count 496, done and status 00 after 1000 in-window cycles.
REQ-040 Bench: count=100, target=-200 -> motor_dir=0, busy=1 throughout the move, done pulse exactly 1 cycle long, then cmd_ready=1.
REQ-041 Bench: count frozen at 0, target=1000, TIMEOUT_CYCLES=200 -> done with status 10 in the 201st post-accept cycle, motor_en=0.
REQ-042 Bench: overshoot to err=-6 during SETTLE -> return to MOVE with motor_dir=0 and the settle count cleared.
REQ-043 Bench: abort and timeout in the same cycle -> status 01; a later abort in IDLE has no effect.
REQ-044 Bench: rst_n pulsed low mid-MOVE -> motor_en=0 asynchronously, no done pulse, cmd_ready=1 one edge after release.
